// File: rtl/graph_scanout_if.sv
// Framebuffer read port between graph_scanout and its byte-wide memory.
// The master issues one-cycle read strobes. The slave returns data at a fixed latency.
interface graph_scanout_if #(
    parameter int ADDR_W = 13
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (output mem_rd, output mem_addr, input mem_data);
    modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/graph_scanout.sv
// Bitmap scan-out engine: raster timing, framebuffer fetch, 1/2 bpp pixel
// expansion with integer scaling, 4-entry palette and border colour.
// Output latency from the raster counters to the pins is MEM_LAT + 3 cycles.
module graph_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b1,
    parameter int FB_W_BYTES = 32,
    parameter int FB_H_LINES = 256,
    parameter int ADDR_W     = 13,
    parameter int SCALE_X    = 1,
    parameter int SCALE_Y    = 1,
    parameter int FB_X0      = 0,
    parameter int FB_Y0      = 0,
    parameter int MEM_LAT    = 1
) (
    input  logic            clk_pixel,
    input  logic            reset_n,
    input  logic            bpp2,
    input  logic [23:0]     pal0,
    input  logic [23:0]     pal1,
    input  logic [23:0]     pal2,
    input  logic [23:0]     pal3,
    input  logic [23:0]     border_rgb,
    graph_scanout_if.master mem,
    output logic [7:0]      red,
    output logic [7:0]      green,
    output logic [7:0]      blue,
    output logic            de,
    output logic            hsync,
    output logic            vsync,
    output logic            frame_start
);

    localparam int HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SX_SH  = (SCALE_X == 4) ? 2 : (SCALE_X == 2) ? 1 : 0;
    localparam int SY_SH  = (SCALE_Y == 4) ? 2 : (SCALE_Y == 2) ? 1 : 0;
    localparam int WIN_W1 = FB_W_BYTES * 8 * SCALE_X;
    localparam int WIN_W2 = FB_W_BYTES * 4 * SCALE_X;
    localparam int WIN_H  = FB_H_LINES * SCALE_Y;

    // Attribute pipeline depth up to the data-capture stage.
    localparam int unsigned DLY = MEM_LAT + 2;

    localparam bit PARAMS_OK =
        (SCALE_X == 1 || SCALE_X == 2 || SCALE_X == 4) &&
        (SCALE_Y == 1 || SCALE_Y == 2 || SCALE_Y == 4) &&
        (MEM_LAT >= 1) && (MEM_LAT <= 3) &&
        (FB_X0 >= 0) && (FB_Y0 >= 0) &&
        (FB_X0 + WIN_W1 <= H_ACTIVE) && (FB_Y0 + WIN_H <= V_ACTIVE) &&
        (HT <= 2048) && (VT <= 2048);

    if (!PARAMS_OK) begin : g_bad_params
        $fatal(1, "graph_scanout: illegal parameter set");
    end

    localparam logic [10:0] CX_LAST = 11'(HT - 1);
    localparam logic [10:0] CY_LAST = 11'(VT - 1);
    localparam logic [10:0] HACT    = 11'(H_ACTIVE);
    localparam logic [10:0] VACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] X0      = 11'(FB_X0);
    localparam logic [10:0] Y0      = 11'(FB_Y0);
    localparam logic [10:0] XEND1   = 11'(FB_X0 + WIN_W1);
    localparam logic [10:0] XEND2   = 11'(FB_X0 + WIN_W2);
    localparam logic [10:0] YEND    = 11'(FB_Y0 + WIN_H);
    localparam logic [10:0] SX_MASK = 11'(SCALE_X - 1);
    localparam logic [31:0] FBW     = 32'(FB_W_BYTES);

    typedef struct packed {
        logic       fs;
        logic       hs;
        logic       vs;
        logic       act;
        logic       win;
        logic       mode;
        logic [2:0] k;
    } pix_t;

    logic [10:0]       cx, cy;
    logic              mode;
    logic              at_origin, mode_cur;
    logic [10:0]       dx, dy, fx, fy, byte_idx;
    logic [2:0]        k;
    logic              in_win, fetch;
    logic [ADDR_W-1:0] addr;
    pix_t              s0;
    pix_t              pipe [DLY];
    logic [DLY-2:0]    first_q;
    logic [7:0]        fetch_byte;
    pix_t              o;
    logic [1:0]        pal_idx;
    logic [23:0]       pal_rgb, pix_rgb;

    // Free-running raster position; cy advances when cx wraps.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cx <= '0;
            cy <= '0;
        end else if (cx == CX_LAST) begin
            cx <= '0;
            cy <= (cy == CY_LAST) ? '0 : cy + 11'd1;
        end else begin
            cx <= cx + 11'd1;
        end
    end

    // Pixel depth is frozen for the frame at position (0,0).
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            mode <= 1'b0;
        end else if (at_origin) begin
            mode <= bpp2;
        end
    end

    // Decode the current raster position: sync, window, framebuffer coordinates and fetch.
    always_comb begin
        at_origin = (cx == '0) && (cy == '0);
        // The origin pixel itself already belongs to the new frame's mode.
        mode_cur  = at_origin ? bpp2 : mode;
        dx        = cx - X0;
        dy        = cy - Y0;
        fx        = dx >> SX_SH;
        fy        = dy >> SY_SH;
        byte_idx  = mode_cur ? (fx >> 2) : (fx >> 3);
        k         = mode_cur ? {1'b0, fx[1:0]} : fx[2:0];
        in_win    = (cx >= X0) && (cx < (mode_cur ? XEND2 : XEND1)) &&
                    (cy >= Y0) && (cy < YEND);
        fetch     = in_win && ((dx & SX_MASK) == '0) && (k == '0);
        addr      = ADDR_W'(32'(fy) * FBW + 32'(byte_idx));
        s0        = '0;
        s0.fs     = at_origin;
        s0.hs     = (cx >= HS_BEG) && (cx < HS_END);
        s0.vs     = (cy >= VS_BEG) && (cy < VS_END);
        s0.act    = (cx < HACT) && (cy < VACT);
        s0.win    = in_win;
        s0.mode   = mode_cur;
        s0.k      = k;
    end

    // One read per byte, issued on that byte's first displayed pixel.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            mem.mem_rd   <= 1'b0;
            mem.mem_addr <= '0;
        end else begin
            mem.mem_rd <= fetch;
            if (fetch) begin
                mem.mem_addr <= addr;
            end
        end
    end

    // Carry pixel attributes and fetch markers alongside the memory latency.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DLY; i++) begin
                pipe[i] <= '0;
            end
            first_q <= '0;
        end else begin
            pipe[0] <= s0;
            for (int unsigned i = 1; i < DLY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            first_q <= {first_q[DLY-3:0], fetch};
        end
    end

    // Prefetch register: take mem_data only in the cycle a requested byte is due.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            fetch_byte <= '0;
        end else if (first_q[DLY-2]) begin
            fetch_byte <= mem.mem_data;
        end
    end

    // Select the palette entry for the pixel leaving the pipeline, or border/blank.
    always_comb begin
        o       = pipe[DLY-1];
        pal_idx = o.mode ? 2'(fetch_byte >> {o.k[1:0], 1'b0}) : {1'b0, fetch_byte[o.k]};
        case (pal_idx)
            2'd0:    pal_rgb = pal0;
            2'd1:    pal_rgb = pal1;
            2'd2:    pal_rgb = pal2;
            default: pal_rgb = pal3;
        endcase
        if (!o.act) begin
            pix_rgb = '0;
        end else if (!o.win) begin
            pix_rgb = border_rgb;
        end else begin
            pix_rgb = pal_rgb;
        end
    end

    // Output register: colour, enable, syncs and frame marker leave together.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            {red, green, blue} <= pix_rgb;
            de                 <= o.act;
            hsync              <= o.hs ? SYNC_POL : ~SYNC_POL;
            vsync              <= o.vs ? SYNC_POL : ~SYNC_POL;
            frame_start        <= o.fs;
        end
    end

endmodule

// File: tb/tb_graph_scanout.sv
// Self-checking bench for graph_scanout. Two instances with reduced timing
// and different scale/latency/offset/polarity run with random framebuffer
// contents, palette and per-cycle bpp2 toggling. Every output cycle is
// compared against a raster-position reference model.
module tb_graph_scanout;

    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 24, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    localparam int A_SX = 1, A_SY = 2, A_X0 = 5, A_Y0 = 2, A_FBW = 4, A_FBH = 10, A_AW = 5, A_LAT = 1;
    localparam bit A_POL = 1'b1;
    localparam int B_SX = 4, B_SY = 4, B_X0 = 3, B_Y0 = 1, B_FBW = 1, B_FBH = 5, B_AW = 3, B_LAT = 3;
    localparam bit B_POL = 1'b0;

    typedef struct {
        int sx, sy, x0, y0, fbw, fbh, aw, pipe;
        bit pol;
    } cfg_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bpp2;
    logic [23:0] pal [4];
    logic [23:0] border;
    logic [7:0]  memA [1 << A_AW];
    logic [7:0]  memB [1 << B_AW];
    bit          fmode [8];
    int          errors, checks;

    logic [7:0] rA, gA, bA, rB, gB, bB;
    logic       deA, hsA, vsA, fsA, deB, hsB, vsB, fsB;

    graph_scanout_if #(.ADDR_W(A_AW)) busA ();
    graph_scanout_if #(.ADDR_W(B_AW)) busB ();

    always #5 clk = ~clk;

    graph_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(A_POL), .FB_W_BYTES(A_FBW), .FB_H_LINES(A_FBH), .ADDR_W(A_AW),
        .SCALE_X(A_SX), .SCALE_Y(A_SY), .FB_X0(A_X0), .FB_Y0(A_Y0), .MEM_LAT(A_LAT)
    ) dut_a (
        .clk_pixel(clk), .reset_n(reset_n), .bpp2(bpp2),
        .pal0(pal[0]), .pal1(pal[1]), .pal2(pal[2]), .pal3(pal[3]), .border_rgb(border),
        .mem(busA), .red(rA), .green(gA), .blue(bA),
        .de(deA), .hsync(hsA), .vsync(vsA), .frame_start(fsA)
    );

    graph_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(B_POL), .FB_W_BYTES(B_FBW), .FB_H_LINES(B_FBH), .ADDR_W(B_AW),
        .SCALE_X(B_SX), .SCALE_Y(B_SY), .FB_X0(B_X0), .FB_Y0(B_Y0), .MEM_LAT(B_LAT)
    ) dut_b (
        .clk_pixel(clk), .reset_n(reset_n), .bpp2(bpp2),
        .pal0(pal[0]), .pal1(pal[1]), .pal2(pal[2]), .pal3(pal[3]), .border_rgb(border),
        .mem(busB), .red(rB), .green(gB), .blue(bB),
        .de(deB), .hsync(hsB), .vsync(vsB), .frame_start(fsB)
    );

    // Memory models: data valid exactly LAT cycles after the strobe, garbage otherwise.
    logic       vA [A_LAT];
    logic [7:0] dA [A_LAT];
    logic [7:0] gnA;
    logic       vB [B_LAT];
    logic [7:0] dB [B_LAT];
    logic [7:0] gnB;

    always @(posedge clk) begin
        vA[0] <= busA.mem_rd;
        dA[0] <= memA[busA.mem_addr];
        for (int i = 1; i < A_LAT; i++) begin
            vA[i] <= vA[i-1];
            dA[i] <= dA[i-1];
        end
        gnA <= 8'($urandom);
        vB[0] <= busB.mem_rd;
        dB[0] <= memB[busB.mem_addr];
        for (int i = 1; i < B_LAT; i++) begin
            vB[i] <= vB[i-1];
            dB[i] <= dB[i-1];
        end
        gnB <= 8'($urandom);
    end

    assign busA.mem_data = vA[A_LAT-1] ? dA[A_LAT-1] : gnA;
    assign busB.mem_data = vB[B_LAT-1] ? dB[B_LAT-1] : gnB;

    function automatic cfg_t get_cfg(input int c);
        cfg_t g;
        if (c == 0) begin
            g.sx = A_SX; g.sy = A_SY; g.x0 = A_X0; g.y0 = A_Y0;
            g.fbw = A_FBW; g.fbh = A_FBH; g.aw = A_AW; g.pipe = A_LAT + 3; g.pol = A_POL;
        end else begin
            g.sx = B_SX; g.sy = B_SY; g.x0 = B_X0; g.y0 = B_Y0;
            g.fbw = B_FBW; g.fbh = B_FBH; g.aw = B_AW; g.pipe = B_LAT + 3; g.pol = B_POL;
        end
        return g;
    endfunction

    // Reference: what raster position p (counted from reset release) must produce.
    function automatic void model(input int c, input int p,
                                  output logic [31:0] vid, output logic rd, output int addr);
        cfg_t g;
        int   cx, cy, ppb, fx, fy, bv, idx;
        bit   md, act, win, hs, vs, fs;
        logic [23:0] rgb;
        g   = get_cfg(c);
        cx  = p % HT;
        cy  = (p / HT) % VT;
        md  = fmode[p / FRAME];
        ppb = md ? 4 : 8;
        act = (cx < HA) && (cy < VA);
        win = (cx >= g.x0) && (cx < g.x0 + g.fbw * ppb * g.sx) &&
              (cy >= g.y0) && (cy < g.y0 + g.fbh * g.sy);
        hs  = (cx >= HA + HF) && (cx < HA + HF + HS);
        vs  = (cy >= VA + VF) && (cy < VA + VF + VS);
        fs  = (cx == 0) && (cy == 0);
        addr = 0;
        rd   = 1'b0;
        idx  = 0;
        if (win) begin
            fx   = (cx - g.x0) / g.sx;
            fy   = (cy - g.y0) / g.sy;
            addr = (fy * g.fbw + fx / ppb) % (1 << g.aw);
            rd   = ((cx - g.x0) % (g.sx * ppb)) == 0;
            bv   = (c == 0) ? int'(memA[addr]) : int'(memB[addr]);
            idx  = md ? ((bv >> (2 * (fx % 4))) & 3) : ((bv >> (fx % 8)) & 1);
        end
        rgb = !act ? 24'h0 : (!win ? border : pal[idx]);
        vid = 32'({act, hs ? g.pol : !g.pol, vs ? g.pol : !g.pol, fs, rgb});
    endfunction

    function automatic logic [31:0] reset_vid(input int c);
        cfg_t g;
        g = get_cfg(c);
        return 32'({1'b0, !g.pol, !g.pol, 1'b0, 24'h0});
    endfunction

    function automatic logic [31:0] obs_vid(input int c);
        if (c == 0) return 32'({deA, hsA, vsA, fsA, rA, gA, bA});
        return 32'({deB, hsB, vsB, fsB, rB, gB, bB});
    endfunction

    function automatic logic [31:0] obs_mem(input int c);
        if (c == 0) return 32'({busA.mem_rd, busA.mem_addr});
        return 32'({busB.mem_rd, busB.mem_addr});
    endfunction

    task automatic chk(input string tag, input int c, input int e,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cycle %0d: got %h expected %h", tag, c, e, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        for (int c = 0; c < 2; c++) begin
            chk({tag, "_video"}, c, -1, obs_vid(c), reset_vid(c));
            chk({tag, "_mem"}, c, -1, obs_mem(c), 32'h0);
        end
    endtask

    // e = clock edges since reset release; video shows position e-PIPE, the read strobe position e-1.
    task automatic check_cycle(input int e);
        cfg_t        g;
        logic [31:0] ev, dv;
        logic        erd, drd;
        int          eaddr, daddr;
        for (int c = 0; c < 2; c++) begin
            g = get_cfg(c);
            if (e < g.pipe) ev = reset_vid(c);
            else model(c, e - g.pipe, ev, drd, daddr);
            chk("video", c, e, obs_vid(c), ev);
            model(c, e - 1, dv, erd, eaddr);
            chk("mem_rd", c, e, 32'(obs_mem(c) >> g.aw), 32'(erd));
            if (erd) chk("mem_addr", c, e, obs_mem(c) & ((32'd1 << g.aw) - 32'd1), 32'(eaddr));
        end
    endtask

    task automatic randomize_env();
        for (int i = 0; i < (1 << A_AW); i++) memA[i] = 8'($urandom);
        for (int i = 0; i < (1 << B_AW); i++) memB[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) pal[i] = 24'($urandom);
        border = 24'($urandom);
    endtask

    // Run n cycles from a reset release; bpp2 is random except at each frame origin.
    task automatic run(input int n, input bit m0);
        int e;
        bit b;
        e = 0;
        for (int i = 0; i < 8; i++) fmode[i] = 1'b0;
        for (int k = 0; k < n; k++) begin
            b = 1'($urandom);
            if (e % FRAME == 0) begin
                b = m0 ^ 1'((e / FRAME) % 2);
                fmode[e / FRAME] = b;
            end
            bpp2 = b;
            @(negedge clk);
            e++;
            check_cycle(e);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        bpp2    = 1'b0;
        randomize_env();
        repeat (3) begin
            @(negedge clk);
            check_reset("rst_init");
        end
        reset_n = 1'b1;
        run(3 * FRAME + 4 * HT + 30, 1'b0);

        // Asynchronous reset in the middle of an active line.
        #2 reset_n = 1'b0;
        #1 check_reset("rst_async");
        randomize_env();
        repeat (4) begin
            @(negedge clk);
            check_reset("rst_hold");
        end
        reset_n = 1'b1;
        run(2 * FRAME + 20, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/graph_scanout.md
# graph_scanout

Parametrised bitmap scan-out engine for the HDMI/VGA display path. It generates programmable video timing and fetches a byte-wide framebuffer with a fixed-latency read port. It expands pixels at 1 or 2 bits per pixel with integer X/Y scaling through a 4-entry palette, and places the image at an offset inside a border colour. Its RGB/DE/sync outputs feed the existing TMDS encoder stage or a plain VGA DAC.

## Interface
Parameters:
- H_ACTIVE, H_FP, H_SYNC, H_BP: default 640, 16, 96, 48. Horizontal timing in pixels.
- V_ACTIVE, V_FP, V_SYNC, V_BP: default 480, 10, 2, 33. Vertical timing in lines.
- SYNC_POL: default 1. Active level of hsync/vsync.
- FB_W_BYTES: default 32. Framebuffer bytes per line.
- FB_H_LINES: default 256. Framebuffer lines.
- ADDR_W: default 13. Memory address width.
- SCALE_X, SCALE_Y: default 1, 1. Pixel replication factor; legal values 1, 2, 4.
- FB_X0, FB_Y0: default 0, 0. Window origin inside the active area.
- MEM_LAT: default 1. Read data latency in cycles; legal values 1..3.

Ports:
- clk_pixel  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- bpp2  in  1  0 = 1 bpp, 1 = 2 bpp. Sampled at frame start only.
- pal0, pal1, pal2, pal3  in  24 each  palette entries, {R,G,B}.
- border_rgb  in  24  colour for active area outside the window.
- mem_rd  out  1  read strobe, one cycle per byte.
- mem_addr  out  ADDR_W  byte address, valid while mem_rd is high.
- mem_data  in  8  read data, valid MEM_LAT cycles after mem_rd.
- red, green, blue  out  8 each  pixel colour.
- de  out  1  active-area enable.
- hsync, vsync  out  1 each  sync outputs at SYNC_POL.
- frame_start  out  1  one-cycle pulse coincident with output pixel (0,0).

## Operation
- Counters: cx counts 0..HT-1, where HT = the sum of the H params. cy counts 0..VT-1 and increments when cx wraps. Counters are 11 bits.
- Active area: cx < H_ACTIVE and cy < V_ACTIVE.
- hsync is asserted for H_ACTIVE+H_FP <= cx < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on cy.
- Mode latch: bpp2 is captured into mode when the counters are at (0,0). The latched mode holds for the whole frame.
- Pixels per byte: PPB = 8 in 1 bpp, 4 in 2 bpp.
- Window: x from FB_X0 to FB_X0 + FB_W_BYTES*PPB*SCALE_X (exclusive); y from FB_Y0 to FB_Y0 + FB_H_LINES*SCALE_Y (exclusive).
- Framebuffer coordinates: fx = (cx-FB_X0)/SCALE_X, fy = (cy-FB_Y0)/SCALE_Y.
- Address: mem_addr = fy*FB_W_BYTES + fx/PPB, taken modulo 2^ADDR_W.
- Fetch rule: exactly one mem_rd per byte per displayed line, issued in address order. Replicated Y lines re-read the same bytes. There is no mem_rd outside window lines.
- Bit order is LSB first.
  - 1 bpp: pixel k is bit k; colour index = {0, bit}.
  - 2 bpp: pixel k uses bits [2k+1:2k].
- Colour selection: index 0..3 selects pal0..pal3.
  - Active area outside the window: border_rgb.
  - Blanking: RGB = 0 and de = 0.
- Parameter legality: the window must fit in the active area using the 1 bpp width. Illegal SCALE_X, SCALE_Y or MEM_LAT values, or a window that does not fit, must fail elaboration.

## Timing
- Pipeline latency is fixed: PIPE = MEM_LAT + 3.
  - Counter position (cx,cy) appears on red/green/blue/de/hsync/vsync/frame_start exactly PIPE cycles later.
  - All seven outputs are aligned to each other.
- Fetch scheduling: mem_rd for a byte is issued early enough that its data is captured before its first pixel leaves the pipeline.
  - Back-to-back bytes at SCALE_X=1 in 2 bpp need a byte every 4 cycles. The prefetch register must sustain this without stalls.
- Reset values while reset_n is low:
  - cx = cy = 0.
  - red = green = blue = 0, de = 0.
  - hsync = vsync = !SYNC_POL.
  - mem_rd = 0, mem_addr = 0, frame_start = 0, mode = 0.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous). Pipeline contents are discarded.
- After release: the first rising edge processes position (0,0). Outputs hold their reset values for PIPE cycles, then frame_start pulses.
- Edge cases:
  - bpp2 changing at any time other than (0,0) has no visible effect until the next frame.
  - mem_data is ignored in every cycle where no read is due.

## Test plan
- Default timing: after reset, frame_start period = 800*525 cycles. hsync is high for 96 cycles starting 656 cycles after each line start. vsync is high on lines 490–491. de is high for 640 cycles per line.
- 1 bpp, scale 1: memory returns 0x01 at addr 0 and 0x00 elsewhere; pal1 = 0xFF0000, pal0 = 0x000000. Output pixel (0,0) = red, (1..7,0) = black. mem_addr sequence is 0..31 on line 0 and 32..63 on line 1.
- 2 bpp, SCALE_X = SCALE_Y = 2: byte 0xE4 at addr 0. Pixels 0–1 = pal0, 2–3 = pal1, 4–5 = pal2, 6–7 = pal3. Lines 0 and 1 both read addr 0..31; line 2 reads 32..63.
- Window offset FB_X0 = 64, FB_Y0 = 112: pixel (63,112) = border_rgb, (64,112) comes from addr 0, line 111 is entirely border. No mem_rd occurs on lines 0..111.
- MEM_LAT = 3 with a memory model driving garbage on non-due cycles: the image matches the MEM_LAT = 1 run shifted by 2 output cycles.
- bpp2 toggled at line 100, and reset_n pulsed low at cx = 300: the mode changes only at the next frame_start. During reset all outputs take reset values at once; the first frame_start comes PIPE cycles after release.
